// File: rtl/fp_pkg.sv
// Shared constants and FSM encoding for the half-precision alignment path.
package fp_pkg;

    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int MAN_W  = FRAC_W + 1;
    localparam int OP_W   = 1 + EXP_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Subnormals share the scale of exponent 1.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of a packed half-precision operand into sign, effective
// exponent, mantissa with hidden bit, and an Inf/NaN flag.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [OP_W-1:0]  op_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] eff_exp_o,
    output logic [MAN_W:1]   mant_o,
    output logic             special_o
);

    logic [EXP_W-1:0]  exp_raw;
    logic [FRAC_W-1:0] frac_raw;

    assign sign_o    = op_i[OP_W-1];
    assign exp_raw   = op_i[OP_W-2 -: EXP_W];
    assign frac_raw  = op_i[FRAC_W-1:0];

    assign eff_exp_o = eff_exp(exp_raw);
    assign mant_o    = {(exp_raw != '0), frac_raw};
    assign special_o = &exp_raw;

endmodule

// File: rtl/fp_align_stage.sv
// Exponent compare and serial mantissa alignment ahead of the mantissa adder.
// Define ALIGN_STICKY_EN to add the sticky output (OR of shifted-out bits).
module fp_align_stage
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W:1]   mant_big,
    output logic [MAN_W:1]   mant_small,
    output logic [EXP_W-1:0] exp_out,
    output logic             sign_big,
    output logic             sign_small,
    output logic             swapped,
`ifdef ALIGN_STICKY_EN
    output logic             sticky,
`endif
    output logic             special
);

    logic             sign_a, sign_b, spec_a, spec_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W:1]   man_a, man_b;

    fp_unpack u_unpack_a (
        .op_i      (op_a),
        .sign_o    (sign_a),
        .eff_exp_o (exp_a),
        .mant_o    (man_a),
        .special_o (spec_a)
    );

    fp_unpack u_unpack_b (
        .op_i      (op_b),
        .sign_o    (sign_b),
        .eff_exp_o (exp_b),
        .mant_o    (man_b),
        .special_o (spec_b)
    );

    // Ties keep A as the big operand.
    logic             a_big;
    logic [EXP_W-1:0] exp_bg, exp_sm, diff;
    logic [MAN_W:1]   man_bg, man_sm;
    logic             sgn_bg, sgn_sm;

    assign a_big  = (exp_a >= exp_b);
    assign exp_bg = a_big ? exp_a  : exp_b;
    assign exp_sm = a_big ? exp_b  : exp_a;
    assign man_bg = a_big ? man_a  : man_b;
    assign man_sm = a_big ? man_b  : man_a;
    assign sgn_bg = a_big ? sign_a : sign_b;
    assign sgn_sm = a_big ? sign_b : sign_a;
    assign diff   = exp_bg - exp_sm;

    state_t           state_q, state_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic [MAN_W:1]   mant_big_q, mant_big_d;
    logic [MAN_W:1]   mant_small_q, mant_small_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic             sign_big_q, sign_big_d;
    logic             sign_small_q, sign_small_d;
    logic             swapped_q, swapped_d;
    logic             special_q, special_d;
`ifdef ALIGN_STICKY_EN
    logic             sticky_q, sticky_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mant_big_d   = mant_big_q;
        mant_small_d = mant_small_q;
        exp_d        = exp_q;
        sign_big_d   = sign_big_q;
        sign_small_d = sign_small_q;
        swapped_d    = swapped_q;
        special_d    = special_q;
`ifdef ALIGN_STICKY_EN
        sticky_d     = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mant_big_d   = man_bg;
                    mant_small_d = man_sm;
                    exp_d        = exp_bg;
                    sign_big_d   = sgn_bg;
                    sign_small_d = sgn_sm;
                    swapped_d    = ~a_big;
                    special_d    = spec_a | spec_b;
`ifdef ALIGN_STICKY_EN
                    sticky_d     = 1'b0;
`endif
                    if (diff == '0) begin
                        state_d = DONE;
                    end else if (diff >= EXP_W'(MAN_W)) begin
                        // Shift would push every bit out: clamp in one step.
                        mant_small_d = '0;
`ifdef ALIGN_STICKY_EN
                        sticky_d     = |man_sm;
`endif
                        state_d      = DONE;
                    end else begin
                        cnt_d   = diff;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mant_small_d = mant_small_q >> 1;
`ifdef ALIGN_STICKY_EN
                sticky_d     = sticky_q | mant_small_q[1];
`endif
                cnt_d        = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mant_big_q   <= '0;
            mant_small_q <= '0;
            exp_q        <= '0;
            sign_big_q   <= 1'b0;
            sign_small_q <= 1'b0;
            swapped_q    <= 1'b0;
            special_q    <= 1'b0;
`ifdef ALIGN_STICKY_EN
            sticky_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mant_big_q   <= mant_big_d;
            mant_small_q <= mant_small_d;
            exp_q        <= exp_d;
            sign_big_q   <= sign_big_d;
            sign_small_q <= sign_small_d;
            swapped_q    <= swapped_d;
            special_q    <= special_d;
`ifdef ALIGN_STICKY_EN
            sticky_q     <= sticky_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign mant_big   = mant_big_q;
    assign mant_small = mant_small_q;
    assign exp_out    = exp_q;
    assign sign_big   = sign_big_q;
    assign sign_small = sign_small_q;
    assign swapped    = swapped_q;
    assign special    = special_q;
`ifdef ALIGN_STICKY_EN
    assign sticky     = sticky_q;
`endif

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage with hand-computed expected values.
module tb_fp_align_stage;
    import fp_pkg::*;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  op_a, op_b;
    logic             out_valid;
    logic             out_ready;
    logic [MAN_W:1]   mant_big, mant_small;
    logic [EXP_W-1:0] exp_out;
    logic             sign_big, sign_small, swapped, special;
`ifdef ALIGN_STICKY_EN
    logic             sticky;
`endif

    int total = 0;
    int bad   = 0;

    fp_align_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .exp_out    (exp_out),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .swapped    (swapped),
`ifdef ALIGN_STICKY_EN
        .sticky     (sticky),
`endif
        .special    (special)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one pair, measure latency, check the result, then release it.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [10:0] e_big, input logic [10:0] e_small,
                          input logic [4:0] e_exp, input logic e_sb, input logic e_ss,
                          input logic e_swp, input logic e_spc, input logic e_stk,
                          input int e_lat);
        int lat;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"},    32'(lat),        32'(e_lat));
        chk({tag, "_mant_big"},   32'(mant_big),   32'(e_big));
        chk({tag, "_mant_small"}, 32'(mant_small), 32'(e_small));
        chk({tag, "_exp_out"},    32'(exp_out),    32'(e_exp));
        chk({tag, "_signs"},      32'({sign_big, sign_small}), 32'({e_sb, e_ss}));
        chk({tag, "_swapped"},    32'(swapped),    32'(e_swp));
        chk({tag, "_special"},    32'(special),    32'(e_spc));
`ifdef ALIGN_STICKY_EN
        chk({tag, "_sticky"},     32'(sticky),     32'(e_stk));
`else
        if (e_stk) begin end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        logic seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_handshake", 32'({in_ready, out_valid}), 32'b10);
        chk("reset_outputs", 32'({mant_big, mant_small, exp_out}), 32'd0);
        chk("reset_flags", 32'({sign_big, sign_small, swapped, special}), 32'd0);

        //      tag       A         B         big     small   exp   sb ss sw sp st lat
        run_op("diff1",  16'h4000, 16'h3C00, 11'h400, 11'h200, 5'd16, 0, 0, 0, 0, 0, 2);
        run_op("swap",   16'hBC00, 16'h4000, 11'h400, 11'h200, 5'd16, 0, 1, 1, 0, 0, 2);
        run_op("tie",    16'h3C00, 16'h3C00, 11'h400, 11'h400, 5'd15, 0, 0, 0, 0, 0, 1);
        run_op("clamp",  16'h7800, 16'h3C00, 11'h400, 11'h000, 5'd30, 0, 0, 0, 0, 1, 1);
        run_op("inf",    16'h7C00, 16'h3C00, 11'h400, 11'h000, 5'd31, 0, 0, 0, 1, 1, 1);
        run_op("subn",   16'h0001, 16'h0400, 11'h001, 11'h400, 5'd1,  0, 0, 0, 0, 0, 1);
        run_op("diff10", 16'h5000, 16'h2BFF, 11'h400, 11'h001, 5'd20, 0, 0, 0, 0, 1, 11);
        run_op("diff11", 16'h5000, 16'h2400, 11'h400, 11'h000, 5'd20, 0, 0, 0, 0, 1, 1);

        // Backpressure: result held in DONE while a new pair is offered.
        op_a = 16'h4200;
        op_b = 16'h3C00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                op_a = 16'h7C00;
                op_b = 16'h0000;
                in_valid = 1'b1;
            end
            tick();
            chk("bp_hold_hs",   32'({in_ready, out_valid}), 32'b01);
            chk("bp_hold_data", 32'({mant_big, mant_small, exp_out}),
                32'({11'h600, 11'h200, 5'd16}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_hs", 32'({in_ready, out_valid}), 32'b10);
        chk("bp_not_captured", 32'({mant_big, exp_out, special}), 32'({11'h600, 5'd16, 1'b0}));

        // Reset during the third SHIFT cycle abandons the operation.
        op_a = 16'h5000;
        op_b = 16'h2800;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_mid_busy", 32'({in_ready, out_valid}), 32'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_hs", 32'({in_ready, out_valid}), 32'b10);
        chk("rst_mid_data", 32'({mant_big, mant_small, exp_out}), 32'd0);
        chk("rst_mid_flags", 32'({sign_big, sign_small, swapped, special}), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("rst_mid_no_result", 32'(seen_valid), 32'd0);

        run_op("after_rst", 16'h5000, 16'h2800, 11'h400, 11'h001, 5'd20, 0, 0, 0, 0, 0, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
